io_port_resp: RTL
=================

# io_port_resp

Z80 I/O-space responder: the target side of the CPU's IORQ_L bus cycles, sitting on the shared address/data buses alongside the memory and port models. It decodes two consecutive port addresses. It inserts programmable wait states and returns bytes from a receive FIFO filled by a host-side source. It captures CPU writes into a transmit holding register, and raises a maskable interrupt answered with a mode-2 vector during the interrupt-acknowledge cycle.

## Interface
- PORT_ADDR, 8'h10, data port; PORT_ADDR+1 is the status/control port (8-bit decode on addr_bus[7:0]).
- FIFO_DEPTH, 4, RX FIFO entries, power of two, 2..16.
- WAIT_CYCLES, 1, clocks WAIT_L is held low per access, 0..7.
- VECTOR, 8'hE0, byte driven during interrupt acknowledge.

- clk  in  1  system clock, all state updates on rising edge.
- rst_L  in  1  asynchronous active-low reset.
- addr_bus  in  16  CPU address bus.
- data_out  in  8  CPU write data.
- data_in  out  8  read data / vector to CPU.
- data_in_en  out  1  high while this block owns data_in.
- M1_L, IORQ_L, RD_L, WR_L  in  1 each  CPU cycle strobes, active low.
- WAIT_L  out  1  wait request, active low.
- INT_L  out  1  interrupt request, active low.
- src_valid, src_data[7:0], src_ready  in/in/out  host push into RX FIFO; transfer when valid&&ready.
- tx_valid, tx_data[7:0], tx_ready  out/out/in  transmit holding register; transfer when valid&&ready.

## Operation
- Registers: RX FIFO, tx_data/tx_valid, ie (interrupt enable), ovr (sticky TX overrun).
- Port read PORT_ADDR returns FIFO head and pops once, or 8'hFF with no pop if empty.
- Port write PORT_ADDR: if !tx_valid, load tx_data and set tx_valid; otherwise the byte is dropped and ovr is set.
- Port read PORT_ADDR+1 returns {5'b0, ovr, tx_valid, rx_nonempty}, then clears ovr.
- Port write PORT_ADDR+1: ie <= data_out[0].
- FSM states:
  - IDLE: on IORQ_L=0, M1_L=1, (RD_L=0 or WR_L=0), decoded address hit -> WAIT (or ACCESS if WAIT_CYCLES=0).
  - WAIT: WAIT_L=0, counter counts WAIT_CYCLES clocks -> ACCESS.
  - ACCESS: on a read, data_in_en=1 with data_in registered. When IORQ_L samples high, side effects (pop/load/ie/ovr clear) commit exactly once -> IDLE.
  - INTACK: entered from IDLE on M1_L=0, IORQ_L=0 while INT_L=0. Drives VECTOR with data_in_en=1 until IORQ_L high -> IDLE. No wait states.
- INT_L = !(ie && rx_nonempty), registered.
- tx_valid clears on tx_valid&&tx_ready.
- src_ready = !full, registered.

## Timing
- Reset values: data_in=8'h00, data_in_en=0, WAIT_L=1, INT_L=1, src_ready=1, tx_valid=0, tx_data=8'h00, FIFO empty, ie=0, ovr=0, FSM IDLE.
- WAIT_L falls one clock after cycle detection and rises after WAIT_CYCLES clocks.
- data_in_en rises the clock WAIT_L rises and falls the clock after IORQ_L is sampled high.
- Push and pop in the same clock: both occur, count unchanged.
- Push at full is never accepted, even if a pop commits in the same clock.
- IORQ_L high while in WAIT: abort to IDLE, no side effects, WAIT_L=1 next clock.
- CPU write with tx_valid&&tx_ready in the same commit clock: the handshake clears first, and the new byte loads without overrun.
- Pointer and count arithmetic wrap modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.
- rst_L low mid-cycle: all outputs return to reset values immediately, and the FIFO is flushed.

## Configuration
- IO_RESP_INT_EN defined: the ie bit, INT_L generation and the INTACK state are present.
- Undefined: INT_L is tied to 1, the INTACK state is absent, acknowledge cycles are ignored (data_in_en stays 0), writes to bit 0 of PORT_ADDR+1 have no effect, and status is unchanged.

## Test plan
- Reset, then IN from 8'h11 -> 8'h00 (FIFO empty, no overrun, tx idle). WAIT_L is low for exactly 1 clock, and data_in_en is 0 after IORQ_L rises.
- Push 8'hA5 and 8'h3C. Two IN cycles at 8'h10 -> 8'hA5 then 8'h3C. A third IN -> 8'hFF, and status reads 8'h00.
- Push 5 bytes with FIFO_DEPTH=4 -> src_ready drops after 4 and the 5th is held. One IN pops, and src_ready returns high the next clock.
- OUT 8'h55 then OUT 8'h66 to 8'h10 with tx_ready=0 -> tx_data=8'h55. Status reads 8'h06 and then 8'h02 on the next read.
- With IO_RESP_INT_EN: OUT 8'h01 to 8'h11 and push one byte -> INT_L low. An M1_L+IORQ_L acknowledge returns 8'hE0. The pop via IN raises INT_L.
- Assert rst_L low during WAIT of an IN with 2 queued bytes -> WAIT_L=1 and data_in_en=0 immediately. After release, status reads 8'h00.

Source files
------------

// File: rtl/io_port_resp.sv
// io_port_resp: Z80 I/O-space responder for two consecutive ports.
//   PORT_ADDR   : data port (read pops RX FIFO, write loads TX holding register)
//   PORT_ADDR+1 : status {5'b0, ovr, tx_valid, rx_nonempty} / control (ie)
// Optional feature macro IO_RESP_INT_EN: interrupt enable bit, INT_L generation
// and the mode-2 interrupt-acknowledge (INTACK) state.
module io_port_resp #(
   parameter logic [7:0] PORT_ADDR   = 8'h10,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         WAIT_CYCLES = 1,
   parameter logic [7:0] VECTOR      = 8'hE0
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic [15:0] addr_bus,
   input  logic [7:0]  data_out,
   output logic [7:0]  data_in,
   output logic        data_in_en,
   input  logic        M1_L,
   input  logic        IORQ_L,
   input  logic        RD_L,
   input  logic        WR_L,
   output logic        WAIT_L,
   output logic        INT_L,
   input  logic        src_valid,
   input  logic [7:0]  src_data,
   output logic        src_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int         PTR_W     = $clog2(FIFO_DEPTH);
   localparam int         CNT_W     = PTR_W + 1;
   localparam logic [7:0] STAT_ADDR = PORT_ADDR + 8'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
`ifdef IO_RESP_INT_EN
      , S_INTACK
`endif
   } state_t;

   state_t             state;
   logic [2:0]         wait_cnt;
   logic               acc_rd;      // latched: cycle is a read
   logic               acc_stat;    // latched: cycle targets the status/control port
   logic               acc_pop;     // latched: data read saw a non-empty FIFO
   logic [7:0]         acc_wbyte;   // latched CPU write byte
   logic               ovr;
   logic               int_l;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count, count_next;
   logic               rx_nonempty, push, pop;

   logic               io_req, go_access, sel_rd, sel_stat, commit;
   logic               wr_data_commit, stat_rd_commit;
   logic [7:0]         status, rd_data;

   // Only the low address byte is decoded; the high byte is intentionally ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_bus[15:8];

   assign rx_nonempty = (count != '0);
   assign push        = src_valid && src_ready;
   assign status      = {5'b0, ovr, tx_valid, rx_nonempty};
   assign io_req      = !IORQ_L && M1_L && (!RD_L || !WR_L) &&
                        ((addr_bus[7:0] == PORT_ADDR) || (addr_bus[7:0] == STAT_ADDR));
   assign commit         = (state == S_ACCESS) && IORQ_L;
   assign pop            = commit && acc_pop;
   assign wr_data_commit = commit && !acc_rd && !acc_stat;
   assign stat_rd_commit = commit && acc_rd && acc_stat;
   assign INT_L          = int_l;

   // Access decode: live bus in IDLE (zero-wait entry), latched values afterwards.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      sel_rd    = acc_rd;
      sel_stat  = acc_stat;
      go_access = 1'b0;
      if (state == S_IDLE) begin
         sel_rd    = !RD_L;
         sel_stat  = (addr_bus[7:0] == STAT_ADDR);
         go_access = io_req && (WAIT_CYCLES == 0);
      end else if (state == S_WAIT) begin
         go_access = !IORQ_L && (wait_cnt == 3'd0);
      end
      rd_data = sel_stat ? status : (rx_nonempty ? mem[rd_ptr] : 8'hFF);
   end

   // Bus-cycle FSM with registered WAIT_L / data_in / data_in_en.
   always_ff @(posedge clk or negedge rst_L) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees pre-edge values regardless of statement order.
      if (!rst_L) begin
         state      <= S_IDLE;
         wait_cnt   <= 3'd0;
         WAIT_L     <= 1'b1;
         data_in    <= 8'h00;
         data_in_en <= 1'b0;
         acc_rd     <= 1'b0;
         acc_stat   <= 1'b0;
         acc_pop    <= 1'b0;
         acc_wbyte  <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
`ifdef IO_RESP_INT_EN
               if (!M1_L && !IORQ_L && !int_l) begin
                  state      <= S_INTACK;
                  data_in    <= VECTOR;
                  data_in_en <= 1'b1;
               end else
`endif
               if (io_req) begin
                  acc_rd   <= !RD_L;
                  acc_stat <= (addr_bus[7:0] == STAT_ADDR);
                  if (WAIT_CYCLES != 0) begin
                     state    <= S_WAIT;
                     WAIT_L   <= 1'b0;
                     wait_cnt <= 3'(WAIT_CYCLES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (IORQ_L) begin
                  state  <= S_IDLE;        // CPU abandoned the cycle: no side effects
                  WAIT_L <= 1'b1;
               end else if (wait_cnt != 3'd0) begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            S_ACCESS: begin
               if (IORQ_L) begin
                  state      <= S_IDLE;
                  data_in_en <= 1'b0;
               end
            end
`ifdef IO_RESP_INT_EN
            S_INTACK: begin
               if (IORQ_L) begin
                  state      <= S_IDLE;
                  data_in_en <= 1'b0;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase

         if (go_access) begin
            state      <= S_ACCESS;
            WAIT_L     <= 1'b1;
            data_in_en <= sel_rd;
            if (sel_rd) data_in <= rd_data;
            acc_pop    <= sel_rd && !sel_stat && rx_nonempty;
            acc_wbyte  <= data_out;
         end
      end
   end

   // Next FIFO occupancy: simultaneous push and pop leave it unchanged.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // FIFO pointers, occupancy and registered src_ready (never ready while full).
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         src_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_next;
         src_ready <= (count_next != CNT_W'(FIFO_DEPTH));
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; resetting the pointers is what flushes the FIFO.
      if (push) mem[wr_ptr] <= src_data;
   end

   // TX holding register: a same-clock handshake frees the slot before the new load.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else if (wr_data_commit && (!tx_valid || tx_ready)) begin
         tx_valid <= 1'b1;
         tx_data  <= acc_wbyte;
      end else if (tx_valid && tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

   // Sticky overrun: set by a dropped write, cleared by a status read.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L)                                      ovr <= 1'b0;
      else if (wr_data_commit && tx_valid && !tx_ready) ovr <= 1'b1;
      else if (stat_rd_commit)                          ovr <= 1'b0;
   end

`ifdef IO_RESP_INT_EN
   logic ie;

   // Interrupt enable and registered active-low interrupt request.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         ie    <= 1'b0;
         int_l <= 1'b1;
      end else begin
         if (commit && !acc_rd && acc_stat) ie <= acc_wbyte[0];
         int_l <= !(ie && rx_nonempty);
      end
   end
`else
   assign int_l = 1'b1;
`endif

endmodule
